// File: rtl/alu_pkg.sv
// Shared opcode encodings and controller state type for the sequential ALU.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_REM = 3'd4;
   localparam logic [2:0] OP_AND = 3'd5;
   localparam logic [2:0] OP_OR  = 3'd6;
   localparam logic [2:0] OP_XOR = 3'd7;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DIV_RUN = 2'd1,
      DONE    = 2'd2
   } state_t;

endpackage

// File: rtl/alu_seq_div.sv
// Unsigned restoring divider, one quotient bit per clock. The start edge
// performs the first step, so all WIDTH bits are ready WIDTH edges after start.
module alu_seq_div #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]    count_q;
   logic             run_q;
   logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
   logic [WIDTH-1:0] src_quo, src_rem, src_dvs;
   logic [WIDTH:0]   trial, diff;
   logic             q_bit;
   logic [WIDTH-1:0] nxt_quo, nxt_rem;

   always_comb begin
      src_quo = start ? dividend : quo_q;
      src_rem = start ? '0 : rem_q;
      src_dvs = start ? divisor : dvs_q;
      trial   = {src_rem, src_quo[WIDTH-1]};
      diff    = trial - {1'b0, src_dvs};
      // partial remainder stays below divisor, so diff[WIDTH] is a clean borrow
      q_bit   = ~diff[WIDTH];
      nxt_rem = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      nxt_quo = {src_quo[WIDTH-2:0], q_bit};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         run_q   <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
      end else if (start) begin
         count_q <= CW'(WIDTH - 1);
         run_q   <= 1'b1;
         quo_q   <= nxt_quo;
         rem_q   <= nxt_rem;
         dvs_q   <= divisor;
      end else if (run_q) begin
         if (count_q != '0) begin
            count_q <= count_q - 1'b1;
            quo_q   <= nxt_quo;
            rem_q   <= nxt_rem;
         end else begin
            run_q <= 1'b0;
         end
      end
   end

   assign done      = run_q && (count_q == '0);
   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/alu_seq.sv
// Registered signed ALU with valid/ready handshakes and an iterative divider.
//   state   | meaning
//   IDLE    | ready for a new operation
//   DIV_RUN | divider iterating on |a| / |b|
//   DONE    | result and flags held until out_ready
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             sign,
   output logic             overflow,
   output logic             parity,
   output logic             zero,
   output logic             div_zero
);

   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   state_t state_q, state_d;

   logic             is_div, b_zero, div_start, div_done, load;
   logic [WIDTH-1:0] abs_a, abs_b, quo, rem;
   logic [WIDTH:0]   sum_w, diff_w;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] res_d;
   logic             carry_d, ovf_d, dz_d;
   logic             q_neg_q, r_neg_q, is_rem_q, min_ovf_q;

   assign is_div    = (op == OP_DIV) || (op == OP_REM);
   assign b_zero    = (b == '0);
   assign div_start = (state_q == IDLE) && in_valid && is_div && !b_zero;
   assign abs_a     = a[WIDTH-1] ? -a : a;
   assign abs_b     = b[WIDTH-1] ? -b : b;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = div_start ? DIV_RUN : DONE;
         DIV_RUN: if (div_done) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);

   alu_seq_div #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .dividend  (abs_a),
      .divisor   (abs_b),
      .done      (div_done),
      .quotient  (quo),
      .remainder (rem)
   );

   always_comb begin
      sum_w   = {1'b0, a} + {1'b0, b};
      diff_w  = {1'b0, a} - {1'b0, b};
      prod    = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
      res_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      dz_d    = 1'b0;
      load    = 1'b0;
      if (state_q == IDLE) begin
         load = in_valid && !div_start;
         case (op)
            OP_ADD: begin
               res_d   = sum_w[WIDTH-1:0];
               carry_d = sum_w[WIDTH];
               ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) && (res_d[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
               res_d   = diff_w[WIDTH-1:0];
               carry_d = diff_w[WIDTH];
               ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) && (res_d[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL: begin
               res_d   = prod[WIDTH-1:0];
               carry_d = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
               ovf_d   = carry_d;
            end
            OP_DIV, OP_REM: begin
               // only the divide-by-zero case completes from IDLE
               ovf_d = 1'b1;
               dz_d  = 1'b1;
            end
            OP_AND:  res_d = a & b;
            OP_OR:   res_d = a | b;
            default: res_d = a ^ b;
         endcase
      end else if (state_q == DIV_RUN) begin
         load = div_done;
         if (is_rem_q) res_d = r_neg_q ? -rem : rem;
         else          res_d = q_neg_q ? -quo : quo;
         ovf_d = !is_rem_q && min_ovf_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result    <= '0;
         carry     <= 1'b0;
         sign      <= 1'b0;
         overflow  <= 1'b0;
         parity    <= 1'b0;
         zero      <= 1'b0;
         div_zero  <= 1'b0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         is_rem_q  <= 1'b0;
         min_ovf_q <= 1'b0;
      end else begin
         if (div_start) begin
            q_neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            r_neg_q   <= a[WIDTH-1];
            is_rem_q  <= (op == OP_REM);
            min_ovf_q <= (a == MIN_VAL) && (b == '1);
         end
         if (load) begin
            result   <= res_d;
            carry    <= carry_d;
            sign     <= res_d[WIDTH-1];
            overflow <= ovf_d;
            parity   <= ~^res_d;
            zero     <= (res_d == '0);
            div_zero <= dz_d;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 with hand-computed expectations.
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] a, b, result;
   logic [2:0] op;
   logic       carry, sign, overflow, parity, zero, div_zero;

   int checks = 0;
   int errors = 0;
   int lat;
   int seen;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .carry(carry), .sign(sign), .overflow(overflow),
      .parity(parity), .zero(zero), .div_zero(div_zero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // flags packed as {carry, sign, overflow, parity, zero, div_zero}
   function automatic logic [5:0] flags();
      return {carry, sign, overflow, parity, zero, div_zero};
   endfunction

   // called #1 after an edge in IDLE; returns edges from accept to out_valid
   task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] opv,
                        output int l);
      a = av; b = bv; op = opv; in_valid = 1'b1;
      @(posedge clk);
      l = 1;
      #1 in_valid = 1'b0;
      while (!out_valid && l < 40) begin
         @(posedge clk);
         l++;
         #1;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("drain_in_ready", in_ready, 1);
   endtask

   task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [2:0] opv, input logic [7:0] er, input logic [5:0] ef,
                         input int el);
      int l;
      issue(av, bv, opv, l);
      chk({tag, "_lat"}, l, el);
      chk({tag, "_res"}, result, er);
      chk({tag, "_flags"}, flags(), ef);
      consume();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", flags(), 6'b000000);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_op("add_ovf",  8'd100, 8'd50,  3'd0, 8'h96, 6'b011100, 1);
      run_op("sub_neg",  8'd5,   8'd7,   3'd1, 8'hFE, 6'b110000, 1);
      run_op("mul_ovf",  8'd16,  8'd8,   3'd2, 8'h80, 6'b111000, 1);
      run_op("mul_min",  8'hF0,  8'd8,   3'd2, 8'h80, 6'b010000, 1);
      run_op("rem_neg",  8'hF9,  8'd2,   3'd4, 8'hFF, 6'b010100, 9);
      run_op("div_zero", 8'd9,   8'd0,   3'd3, 8'h00, 6'b001111, 1);
      run_op("div_min",  8'h80,  8'hFF,  3'd3, 8'h80, 6'b011000, 9);
      run_op("rem_min",  8'h80,  8'hFF,  3'd4, 8'h00, 6'b000110, 9);
      run_op("and",      8'hF0,  8'h3C,  3'd5, 8'h30, 6'b000100, 1);
      run_op("or",       8'h81,  8'h02,  3'd6, 8'h83, 6'b010000, 1);
      run_op("xor_zero", 8'h5A,  8'h5A,  3'd7, 8'h00, 6'b000110, 1);
      run_op("add_wrap", 8'hFF,  8'h01,  3'd0, 8'h00, 6'b100110, 1);

      // DIV -7/2 then hold in DONE while inputs change underneath
      issue(8'hF9, 8'd2, 3'd3, lat);
      chk("div_lat", lat, 9);
      chk("div_res", result, 8'hFD);
      chk("div_flags", flags(), 6'b010000);
      a = 8'h11; b = 8'h22; op = 3'd0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_res", result, 8'hFD);
         chk("bp_flags", flags(), 6'b010000);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
      end
      in_valid = 1'b0;
      consume();

      // reset during DIV_RUN cycle 4
      a = 8'hF9; b = 8'd2; op = 3'd3; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("run_in_ready", in_ready, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_result", result, 0);
      rst = 1'b0;
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      chk("abort_no_output", seen, 0);

      run_op("post_rst", 8'd3, 8'd4, 3'd0, 8'h07, 6'b000000, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
